dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port `DataMemory` word store: 32-bit data, 14-bit address, 16 words, one-cycle registered read. It shares the memory between the CPU load/store port (read/write) and the VGA pixel fetch port (read-only). It drives the memory's `enable`/`read_enable`/`write_enable`/`address`/`input_data` and returns read data with a valid pulse. VGA has priority; a starvation counter guarantees CPU progress.

## Interface
- `ADDR_W`, 14, address width (matches memory `address`)
- `DATA_W`, 32, data width
- `DEPTH`, 16, number of implemented memory words
- `STARVE_MAX`, 4, consecutive VGA grants tolerated while CPU waits (≥1)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cpu_req` / `cpu_we`  in  1 / 1  CPU request / 1=write, 0=read
- `cpu_addr` / `cpu_wdata`  in  ADDR_W / DATA_W  CPU word address / write data
- `cpu_ack`  out  1  one-cycle grant pulse; request consumed
- `cpu_rvalid` / `cpu_rdata`  out  1 / DATA_W  read-data pulse / read data (held until next CPU read)
- `cpu_err`  out  1  out-of-range pulse (see Configuration)
- `vga_req` / `vga_addr`  in  1 / ADDR_W  VGA read request / address
- `vga_ack`, `vga_rvalid`, `vga_rdata`, `vga_err`  out  as CPU equivalents
- `mem_enable`, `mem_read_enable`, `mem_write_enable`  out  1 each  memory controls
- `mem_address` / `mem_input_data`  out  ADDR_W / DATA_W  memory address / write data
- `mem_output_data`  in  DATA_W  memory read data

## Operation
- FSM `IDLE` → `CMD` → (`WAIT` if read) → `IDLE`. One transaction outstanding at a time.
- `IDLE`: if any req, pick winner, register command and owner, go `CMD`. With no req, stay in `IDLE`.
- Winner: VGA if `vga_req`, unless `cpu_req` && `starve_cnt == STARVE_MAX`, then CPU. CPU if only `cpu_req`.
- `CMD`: `mem_enable=1`, `mem_read_enable=~we`, `mem_write_enable=we`, address/data registered from the winner. The owner's `ack` is high this cycle only. A write goes to `IDLE` next; a read goes to `WAIT`.
- `WAIT`: all mem controls 0. At the end-of-cycle edge, the owner's `rdata` register loads `mem_output_data`. The owner's `rvalid` pulses the next cycle, which is `IDLE`.
- `starve_cnt` (saturating, 0..STARVE_MAX):
  - +1 on each VGA grant while `cpu_req`=1.
  - Cleared on CPU grant.
  - Cleared in any cycle with `cpu_req`=0.
- Requesters hold req/addr/data stable until ack. A req still high in the cycle after ack is a new request.
- Simultaneous new grant and pending `rvalid`: allowed; `rvalid` belongs to the previous owner.

## Timing
- Request sampled in `IDLE` cycle T → ack in T+1 → write committed at end of T+1.
- Read: data captured at end of T+2 → `rvalid` + `rdata` at T+3. Read latency is 3 cycles from first req cycle.
- Peak throughput: one write per 2 cycles; one read per 3 cycles.
- Reset values, applied immediately on `rst_n`=0:
  - All `ack`/`rvalid`/`err` = 0, `rdata` = 0.
  - All `mem_*` outputs = 0.
  - FSM = `IDLE`, `starve_cnt` = 0.
- Reset mid-transaction abandons it: no `rvalid` after release. A write whose `CMD` cycle was cut by reset must not be issued.

## Configuration
- `DMEM_ARB_ADDR_CHECK_EN` defined:
  - A granted address ≥ `DEPTH` still produces `ack` in `CMD`.
  - The owner's `err` pulses with `ack`, `mem_enable` stays 0, and there is no `WAIT`/`rvalid`. `rdata` is unchanged.
  - FSM returns to `IDLE`.
- Not defined: `cpu_err`/`vga_err` tied 0. Address passed unchecked to memory.

## Test plan
- CPU write addr 3 = 0xDEADBEEF, then CPU read addr 3 → acks in T+1, `cpu_rvalid` at T+3 with `cpu_rdata`=0xDEADBEEF; `mem_write_enable` high exactly one cycle.
- `cpu_req` and `vga_req` both held high continuously, `STARVE_MAX`=4 → grant order VGA×4, CPU, VGA×4, CPU; `starve_cnt` cleared after each CPU grant.
- CPU write addr 0 = 0x00FF00FF, then VGA read addr 0 → `vga_rvalid` with 0x00FF00FF; `cpu_rvalid` stays 0.
- CPU write addr 20 with macro → `cpu_err`=1 in ack cycle, `mem_enable` never high, next read addr 4 (20 mod 16) returns its old value. Without macro → `cpu_err` stays 0.
- `rst_n` low during `WAIT` of VGA read → all outputs 0 that cycle, no `vga_rvalid` after release; following CPU read served with 3-cycle latency.
- CPU back-to-back writes addr 1, 2 with req held → acks at T+1 and T+3, memory holds both values.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port DataMemory (16 x 32-bit words, one-cycle registered
// read) between the CPU load/store port and the VGA pixel fetch port.
// VGA normally wins. A starvation counter hands the memory to the CPU after
// STARVE_MAX consecutive VGA grants made while the CPU was waiting.
//
// Optional feature: define DMEM_ARB_ADDR_CHECK_EN to reject addresses >= DEPTH.
// A rejected request is still acked, pulses the owner's err flag, and never
// reaches the memory. Without the macro the err outputs stay 0 and the address
// goes to the memory unchecked.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request (we=1 write, 0 read)
//   cpu_ack/cpu_rvalid/cpu_rdata/cpu_err CPU grant pulse, read return, error
//   vga_req/vga_addr                VGA read request
//   vga_ack/vga_rvalid/vga_rdata/vga_err VGA grant pulse, read return, error
//   mem_enable/mem_read_enable/mem_write_enable/mem_address/mem_input_data
//                                   memory command (all registered)
//   mem_output_data                 memory read data (valid the cycle after CMD)
module dmem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_err,
  output logic              mem_enable,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_input_data,
  input  logic [DATA_W-1:0] mem_output_data
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

`ifdef DMEM_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   starve_cnt;
  logic               owner_vga;
  logic               cmd_we;
  logic               cmd_bad;

  logic               grant_vga;
  logic               grant_cpu;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;
  logic               sel_bad;

  // Winner selection for an IDLE cycle: VGA unless the CPU has been passed
  // over STARVE_MAX times in a row.
  always_comb begin
    grant_vga = vga_req && !(cpu_req && (starve_cnt == CNT_MAX));
    grant_cpu = cpu_req && !grant_vga;
    sel_addr  = grant_vga ? vga_addr : cpu_addr;
    sel_we    = grant_vga ? 1'b0 : cpu_we;
    sel_wdata = grant_vga ? '0 : cpu_wdata;
    sel_bad   = ADDR_CHECK && (32'(sel_addr) >= 32'(DEPTH));
  end

  // Sequencer. Every output is registered so that acks, mem commands and
  // rvalid pulses all line up with the state they belong to; pulses default
  // to 0 each cycle and are raised only on the edge that enters their cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      starve_cnt       <= '0;
      owner_vga        <= 1'b0;
      cmd_we           <= 1'b0;
      cmd_bad          <= 1'b0;
      cpu_ack          <= 1'b0;
      cpu_rvalid       <= 1'b0;
      cpu_rdata        <= '0;
      cpu_err          <= 1'b0;
      vga_ack          <= 1'b0;
      vga_rvalid       <= 1'b0;
      vga_rdata        <= '0;
      vga_err          <= 1'b0;
      mem_enable       <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_input_data   <= '0;
    end else begin
      cpu_ack          <= 1'b0;
      vga_ack          <= 1'b0;
      cpu_err          <= 1'b0;
      vga_err          <= 1'b0;
      cpu_rvalid       <= 1'b0;
      vga_rvalid       <= 1'b0;
      mem_enable       <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;

      // Starvation only counts while the CPU is actually waiting; any cycle
      // without a CPU request forgets the history.
      if (!cpu_req) begin
        starve_cnt <= '0;
      end else if (state == IDLE && grant_cpu) begin
        starve_cnt <= '0;
      end else if (state == IDLE && grant_vga && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (cpu_req || vga_req) begin
            owner_vga        <= grant_vga;
            cmd_we           <= sel_we;
            cmd_bad          <= sel_bad;
            cpu_ack          <= grant_cpu;
            vga_ack          <= grant_vga;
            cpu_err          <= grant_cpu && sel_bad;
            vga_err          <= grant_vga && sel_bad;
            mem_enable       <= !sel_bad;
            mem_read_enable  <= !sel_bad && !sel_we;
            mem_write_enable <= !sel_bad && sel_we;
            mem_address      <= sel_addr;
            mem_input_data   <= sel_wdata;
            state            <= CMD;
          end
        end
        CMD: begin
          // Writes and rejected commands have nothing to wait for.
          state <= (cmd_we || cmd_bad) ? IDLE : WAIT;
        end
        WAIT: begin
          if (owner_vga) begin
            vga_rdata  <= mem_output_data;
            vga_rvalid <= 1'b1;
          end else begin
            cpu_rdata  <= mem_output_data;
            cpu_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. Contains a behavioural DataMemory
// (16 words, one-cycle registered read) plus a reference model: a golden word
// array, the last read value per port, and a simple grant-order counter.
module tb_dmem_arbiter;

  localparam int STARVE_MAX = 4;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;
  logic        vga_req;
  logic [13:0] vga_addr;
  logic        vga_ack, vga_rvalid, vga_err;
  logic [31:0] vga_rdata;
  logic        mem_enable, mem_read_enable, mem_write_enable;
  logic [13:0] mem_address;
  logic [31:0] mem_input_data;
  logic [31:0] mem_output_data;

  logic [31:0] mem_array [16];
  logic        mem_init;

  logic [31:0] ref_mem [16];
  logic [31:0] last_cpu_rdata;
  logic [31:0] last_vga_rdata;
  int          n_asserts = 0;
  int          n_fail    = 0;

  dmem_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_ack          (cpu_ack),
    .cpu_rvalid       (cpu_rvalid),
    .cpu_rdata        (cpu_rdata),
    .cpu_err          (cpu_err),
    .vga_req          (vga_req),
    .vga_addr         (vga_addr),
    .vga_ack          (vga_ack),
    .vga_rvalid       (vga_rvalid),
    .vga_rdata        (vga_rdata),
    .vga_err          (vga_err),
    .mem_enable       (mem_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_input_data   (mem_input_data),
    .mem_output_data  (mem_output_data)
  );

  always #5 clk = ~clk;

  // Behavioural DataMemory: low address bits select one of 16 words.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem_array[i] <= 32'h1000_0000 + i;
      mem_output_data <= '0;
    end else if (mem_enable) begin
      if (mem_write_enable) mem_array[mem_address[3:0]] <= mem_input_data;
      if (mem_read_enable)  mem_output_data <= mem_array[mem_address[3:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [13:0] a);
    return ADDR_CHECK && (int'(a) >= 16);
  endfunction

  function automatic int word_of(input logic [13:0] a);
    return int'(a) % 16;
  endfunction

  // One CPU write starting in the current (IDLE) cycle T.
  task automatic cpu_write(input logic [13:0] a, input logic [31:0] d);
    bit bad = is_bad(a);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();  // T+1
    check_output("wr_ack", {cpu_ack, vga_ack, cpu_err}, {1'b1, 1'b0, bad});
    check_output("wr_mem_ctl", {mem_enable, mem_write_enable, mem_read_enable}, {!bad, !bad, 1'b0});
    check_output("wr_mem_addr", mem_address, a);
    if (!bad) check_output("wr_mem_data", mem_input_data, d);
    cpu_req = 1'b0;
    tick();  // T+2
    check_output("wr_we_one_cycle", {mem_write_enable, cpu_ack}, 2'b00);
    if (!bad) ref_mem[word_of(a)] = d;
  endtask

  // One CPU read starting in the current (IDLE) cycle T.
  task automatic cpu_read(input logic [13:0] a);
    bit bad = is_bad(a);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    tick();  // T+1
    check_output("rd_ack", {cpu_ack, vga_ack, cpu_err}, {1'b1, 1'b0, bad});
    check_output("rd_mem_ctl", {mem_enable, mem_read_enable, mem_write_enable}, {!bad, !bad, 1'b0});
    cpu_req = 1'b0;
    tick();  // T+2
    check_output("rd_no_early_rvalid", cpu_rvalid, 1'b0);
    tick();  // T+3
    if (!bad) last_cpu_rdata = ref_mem[word_of(a)];
    check_output("rd_rvalid", {cpu_rvalid, vga_rvalid}, {!bad, 1'b0});
    check_output("rd_data", cpu_rdata, last_cpu_rdata);
  endtask

  // One VGA read starting in the current (IDLE) cycle T.
  task automatic vga_read(input logic [13:0] a);
    bit bad = is_bad(a);
    vga_req = 1'b1; vga_addr = a;
    tick();  // T+1
    check_output("vga_ack", {vga_ack, cpu_ack, vga_err}, {1'b1, 1'b0, bad});
    check_output("vga_mem_ctl", {mem_enable, mem_read_enable}, {!bad, !bad});
    vga_req = 1'b0;
    tick();  // T+2
    tick();  // T+3
    if (!bad) last_vga_rdata = ref_mem[word_of(a)];
    check_output("vga_rvalid", {vga_rvalid, cpu_rvalid}, {!bad, 1'b0});
    check_output("vga_data", vga_rdata, last_vga_rdata);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_flags"},
                 {cpu_ack, vga_ack, cpu_rvalid, vga_rvalid, cpu_err, vga_err,
                  mem_enable, mem_read_enable, mem_write_enable}, 9'b0);
    check_output({tag, "_rdata"}, {cpu_rdata, vga_rdata}, 64'd0);
    check_output({tag, "_mem_bus"}, {18'd0, mem_address, mem_input_data}, 64'd0);
  endtask

  task automatic apply_stimulus();
    int  model_cnt;
    int  grants;
    int  cycles;
    bit  exp_vga;
    int  pick;
    logic [13:0] ra;

    // Reset state
    rst_n = 1'b0; mem_init = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + i;
    last_cpu_rdata = '0; last_vga_rdata = '0;
    tick(); tick();
    mem_init = 1'b0;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    $display("[TB] write/read addr 3");
    cpu_write(14'd3, 32'hDEADBEEF);
    cpu_read(14'd3);

    $display("[TB] CPU write then VGA read addr 0");
    cpu_write(14'd0, 32'h00FF00FF);
    vga_read(14'd0);

    $display("[TB] out-of-range write addr 20, read addr 4");
    cpu_write(14'd20, 32'hCAFE_0020);
    cpu_read(14'd4);

    $display("[TB] back-to-back writes addr 1, 2");
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'd1; cpu_wdata = 32'hAAAA_0001;
    tick();
    check_output("b2b_ack1", {cpu_ack, mem_write_enable}, 2'b11);
    cpu_addr = 14'd2; cpu_wdata = 32'hBBBB_0002;
    tick();
    check_output("b2b_gap", {cpu_ack, mem_write_enable}, 2'b00);
    tick();
    check_output("b2b_ack2", {cpu_ack, mem_write_enable}, 2'b11);
    check_output("b2b_addr2", {mem_address, mem_input_data}, {14'd2, 32'hBBBB_0002});
    cpu_req = 1'b0;
    tick();
    ref_mem[1] = 32'hAAAA_0001;
    ref_mem[2] = 32'hBBBB_0002;
    cpu_read(14'd1);
    cpu_read(14'd2);

    $display("[TB] starvation: both ports held");
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'd5; cpu_wdata = 32'h5555_AAAA;
    vga_req = 1'b1; vga_addr = 14'd7;
    model_cnt = 0; grants = 0; cycles = 0;
    while (grants < 10 && cycles < 80) begin
      tick();
      cycles++;
      if (vga_rvalid) check_output("starve_vga_data", vga_rdata, ref_mem[7]);
      if (cpu_ack || vga_ack) begin
        exp_vga = (model_cnt != STARVE_MAX);
        model_cnt = exp_vga ? model_cnt + 1 : 0;
        check_output($sformatf("grant_%0d", grants), {cpu_ack, vga_ack}, {!exp_vga, exp_vga});
        grants++;
      end
    end
    if (grants < 10) check_output("grant_budget", grants, 10);
    cpu_req = 1'b0; vga_req = 1'b0;
    ref_mem[5] = 32'h5555_AAAA;
    last_vga_rdata = ref_mem[7];
    tick(); tick(); tick();

    $display("[TB] reset during VGA WAIT");
    vga_req = 1'b1; vga_addr = 14'd9;
    tick();
    vga_req = 1'b0;
    tick();  // WAIT
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    #1;
    rst_n = 1'b1;
    last_cpu_rdata = '0; last_vga_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("no_rvalid_after_reset", {vga_rvalid, cpu_rvalid}, 2'b00);
    end
    cpu_read(14'd9);

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 2);
      ra = 14'($urandom_range(0, 19));
      if (pick == 0) cpu_write(ra, $urandom);
      else if (pick == 1) cpu_read(ra);
      else vga_read(ra);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    apply_stimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
